keypad_scanner: RTL
===================

Name: keypad_scanner

Overview:
Parametrised matrix-keypad scanner that replaces the purely combinational row/column decoder. It drives columns one at a time, synchronises and debounces the row returns, and reports each accepted key press as a single-cycle event with a registered key code. It sits between the board keypad pins and the downstream hex/display logic.

Parameters:
N_ROWS, 4, number of keypad rows (≥2)
N_COLS, 4, number of keypad columns (≥2)
SCAN_DIV, 5000, clk cycles per column dwell / sample period (≥3, to cover synchroniser latency)
DEBOUNCE_SCANS, 20, consecutive agreeing samples required to accept a press or a release (≥1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
row_n  input  N_ROWS  asynchronous row returns, active-low (pulled up externally)
col_n  output  N_COLS  column drive, one-hot active-low
key_code  output  CODE_W  row*N_COLS+col of the last accepted key; CODE_W=$clog2(N_ROWS*N_COLS)
key_valid  output  1  one-cycle pulse when a press is accepted
key_held  output  1  high from acceptance until release is accepted

Behaviour:
- Reset (reset==0 at posedge): col_n all ones; key_code=0; key_valid=0; key_held=0; synchroniser flops all ones; dwell/debounce counters 0; state SCAN, column index 0.
- First cycle after reset deasserts: col_n drives column 0 (e.g. 4'b1110).
- row_n passes through a 2-flop synchroniser; all decisions use the synchronised value (rs).
- Dwell counter runs 0..SCAN_DIV-1 in every state. "Sample" means the cycle where dwell==SCAN_DIV-1.
- SCAN: at sample, inspect rs.
  - Exactly one row low: capture row r and column c; set debounce count to 1; go to DEBOUNCE with the column frozen.
  - No rows low: advance column; N_COLS-1 wraps to 0.
  - More than one row low: ambiguous, so advance the column.
- DEBOUNCE: at each sample, if only row r is low, count+1; otherwise go to SCAN at the next column.
  - When count reaches DEBOUNCE_SCANS, go to HELD. On the next cycle key_valid=1 for exactly one cycle, key_code=r*N_COLS+c, and key_held=1.
  - If DEBOUNCE_SCANS==1, the detecting sample itself accepts the press.
- HELD: the column stays frozen and only row r is watched. Other keys, including other rows in the same column, are ignored.
  - At a sample where row r is high: count=1 and go to RELEASE.
- RELEASE: at each sample, row r high gives count+1; row r low sends the block back to HELD with no new key_valid.
  - When count reaches DEBOUNCE_SCANS: key_held=0 next cycle, go to SCAN at the next column.
- key_code holds its value until the next accepted press. key_valid never repeats while a key is held (no autorepeat).
- Press latency: key_valid asserts 1 cycle after the DEBOUNCE_SCANS-th agreeing sample.
- Reset mid-operation (any state) returns every output to its reset value at that edge; any pending press is discarded.
- Counter widths: dwell $clog2(SCAN_DIV); debounce $clog2(DEBOUNCE_SCANS+1). No overflow is possible because the counter saturates at the state exit.

Decomposition:
- Package keypad_pkg holds:
  - state enum {SCAN, DEBOUNCE, HELD, RELEASE}
  - CODE_W helper function
  - key_to_hex function (4x4 code→hex map) for downstream display logic
- Sub-module sync_2ff (parametrised width, reset value all ones) for the row synchroniser.
- FSM, counters and column drive live in keypad_scanner.

Test Plan:
Bench uses SCAN_DIV=4, DEBOUNCE_SCANS=3, 4x4. The keypad model pulls row_n[r]=0 while col_n[c]==0 and key (r,c) is pressed.
1. reset=0 for 3 cycles → col_n=4'b1111, key_valid=0, key_held=0, key_code=0; first cycle after release → col_n=4'b1110.
2. Press (r2,c1) steady for 40 cycles → exactly one key_valid pulse with key_code=9 and key_held=1; release → key_held=0 after 3 high samples, then scanning resumes at column 2.
3. Press (r0,c3) → detected only after columns 0..2 are scanned. Release, then press (r1,c0) → shows wrap-around, key_code=4.
4. Press (r3,c0) for 1 sample then release → no key_valid, state back to SCAN. Then, while (r1,c2) is HELD, make it high for 2 samples then low → key_held stays 1 with no second pulse.
5. Ghost and multi-key cases:
   - (r0,c2)+(r3,c2) together → no key_valid.
   - (r1,c1) held, then (r2,c3) added → no pulse for code 11 until (r1,c1) is released and (r2,c3) is re-scanned.
6. Assert reset during HELD → next cycle outputs at reset values. Deassert with the key still pressed → key re-accepted with a single pulse, same key_code.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared types and helpers for the matrix-keypad scanner and the logic
// downstream of it.
//   state_t     : scanner FSM states
//   code_w()    : key-code width for a given matrix size
//   key_to_hex(): maps a 4x4 key code onto the legend printed on a standard
//                 hex keypad (1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D).
//                 '*' and '#' are shown as E and F.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_t;

  function automatic int code_w(input int rows, input int cols);
    return (rows * cols > 1) ? $clog2(rows * cols) : 1;
  endfunction

  function automatic logic [3:0] key_to_hex(input logic [3:0] code);
    logic [3:0] hex;
    case (code)
      4'd0:    hex = 4'h1;
      4'd1:    hex = 4'h2;
      4'd2:    hex = 4'h3;
      4'd3:    hex = 4'hA;
      4'd4:    hex = 4'h4;
      4'd5:    hex = 4'h5;
      4'd6:    hex = 4'h6;
      4'd7:    hex = 4'hB;
      4'd8:    hex = 4'h7;
      4'd9:    hex = 4'h8;
      4'd10:   hex = 4'h9;
      4'd11:   hex = 4'hC;
      4'd12:   hex = 4'hE;
      4'd13:   hex = 4'h0;
      4'd14:   hex = 4'hF;
      default: hex = 4'hD;
    endcase
    return hex;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if
// Bundles the keypad pins and the key-event outputs of the scanner.
//   row_n     : row returns from the keypad, active-low
//   col_n     : one-hot active-low column drive
//   key_code  : row*N_COLS+col of the last accepted key
//   key_valid : one-cycle pulse per accepted press
//   key_held  : high while the accepted key is down
// master = scanner side, slave = keypad/consumer side.
interface keypad_scanner_if
  import keypad_pkg::*;
#(
  parameter int N_ROWS = 4,
  parameter int N_COLS = 4
);

  localparam int CODE_W = code_w(N_ROWS, N_COLS);

  logic [N_ROWS-1:0] row_n;
  logic [N_COLS-1:0] col_n;
  logic [CODE_W-1:0] key_code;
  logic              key_valid;
  logic              key_held;

  modport master (
    input  row_n,
    output col_n,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output row_n,
    input  col_n,
    input  key_code,
    input  key_valid,
    input  key_held
  );

endinterface

// File: rtl/sync_2ff.sv
// sync_2ff
// Two-flop synchroniser for asynchronous inputs. Both stages reset to all
// ones so that idle (pulled-up) lines read as inactive straight out of reset.
//   clk   : system clock
//   reset : synchronous, active-low reset
//   d     : asynchronous input
//   q     : synchronised output, two cycles behind d
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
// Scans a matrix keypad one column at a time, debounces the synchronised
// row returns and reports each accepted press once.
//   clk   : system clock
//   reset : synchronous, active-low reset
//   kp    : keypad_scanner_if.master (row_n in; col_n, key_code,
//           key_valid, key_held out)
// Every decision is taken on a "sample" cycle, once per SCAN_DIV cycles.
// While a key is being debounced, held or released the column stays
// frozen and only the captured row is of interest.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int N_ROWS         = 4,
  parameter int N_COLS         = 4,
  parameter int SCAN_DIV       = 5000,
  parameter int DEBOUNCE_SCANS = 20
) (
  input logic             clk,
  input logic             reset,
  keypad_scanner_if.master kp
);

  localparam int CODE_W = code_w(N_ROWS, N_COLS);
  localparam int ROW_W  = $clog2(N_ROWS);
  localparam int COL_W  = $clog2(N_COLS);
  localparam int DIV_W  = $clog2(SCAN_DIV);
  localparam int DEB_W  = $clog2(DEBOUNCE_SCANS + 1);

  state_t              state;
  logic [DIV_W-1:0]    dwell;
  logic [DEB_W-1:0]    deb_cnt;
  logic [COL_W-1:0]    col_idx;
  logic [ROW_W-1:0]    row_r;
  logic [N_COLS-1:0]   col_n_q;
  logic [CODE_W-1:0]   key_code_q;
  logic                key_valid_q;
  logic                key_held_q;

  logic [N_ROWS-1:0]   rs;
  logic [N_ROWS-1:0]   act;
  logic [ROW_W-1:0]    low_row;
  logic                one_low;
  logic                only_r_low;
  logic                r_high;
  logic                sample;
  logic [DEB_W-1:0]    deb_inc;
  logic                deb_done;
  logic [COL_W-1:0]    col_next;

  function automatic logic [N_COLS-1:0] col_drive(input logic [COL_W-1:0] idx);
    return ~(N_COLS'(1) << idx);
  endfunction

  function automatic logic [CODE_W-1:0] code_of(input logic [ROW_W-1:0] row,
                                                input logic [COL_W-1:0] col);
    return CODE_W'(row) * CODE_W'(N_COLS) + CODE_W'(col);
  endfunction

  sync_2ff #(
    .WIDTH(N_ROWS)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (kp.row_n),
    .q    (rs)
  );

  // Row analysis on the synchronised returns. A value with exactly one bit
  // set is the only case where clearing its lowest set bit leaves zero.
  assign act        = ~rs;
  assign one_low    = (act != '0) && ((act & (act - 1'b1)) == '0);
  assign only_r_low = (rs == ~(N_ROWS'(1) << row_r));
  assign r_high     = rs[row_r];

  always_comb begin
    low_row = '0;
    for (int i = 0; i < N_ROWS; i++) begin
      if (act[i]) low_row = ROW_W'(i);
    end
  end

  assign sample   = (dwell == DIV_W'(SCAN_DIV - 1));
  assign deb_inc  = deb_cnt + 1'b1;
  assign deb_done = (deb_inc == DEB_W'(DEBOUNCE_SCANS));
  assign col_next = (col_idx == COL_W'(N_COLS - 1)) ? '0 : col_idx + 1'b1;

  // Scanner FSM. col_n is registered and follows col_idx; wherever the
  // column advances, col_n is loaded with the new column in the same edge
  // so the drive never lags the index.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= SCAN;
      dwell       <= '0;
      deb_cnt     <= '0;
      col_idx     <= '0;
      row_r       <= '0;
      col_n_q     <= '1;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      dwell       <= sample ? '0 : dwell + 1'b1;
      key_valid_q <= 1'b0;
      col_n_q     <= col_drive(col_idx);
      if (sample) begin
        case (state)
          SCAN: begin
            if (one_low) begin
              row_r   <= low_row;
              deb_cnt <= DEB_W'(1);
              if (DEBOUNCE_SCANS == 1) begin
                state       <= HELD;
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
                key_code_q  <= code_of(low_row, col_idx);
              end else begin
                state <= DEBOUNCE;
              end
            end else begin
              col_idx <= col_next;
              col_n_q <= col_drive(col_next);
            end
          end
          DEBOUNCE: begin
            if (only_r_low) begin
              deb_cnt <= deb_inc;
              if (deb_done) begin
                state       <= HELD;
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
                key_code_q  <= code_of(row_r, col_idx);
              end
            end else begin
              state   <= SCAN;
              col_idx <= col_next;
              col_n_q <= col_drive(col_next);
            end
          end
          HELD: begin
            if (r_high) begin
              deb_cnt <= DEB_W'(1);
              if (DEBOUNCE_SCANS == 1) begin
                state      <= SCAN;
                key_held_q <= 1'b0;
                col_idx    <= col_next;
                col_n_q    <= col_drive(col_next);
              end else begin
                state <= RELEASE;
              end
            end
          end
          RELEASE: begin
            if (r_high) begin
              deb_cnt <= deb_inc;
              if (deb_done) begin
                state      <= SCAN;
                key_held_q <= 1'b0;
                col_idx    <= col_next;
                col_n_q    <= col_drive(col_next);
              end
            end else begin
              // Bounce back down: still the same press, so no new event.
              state <= HELD;
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

  assign kp.col_n     = col_n_q;
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held_q;

endmodule
